tap_controller: RTL and testbench

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller_if.sv | 24 ++
 rtl/tap_controller.sv | 130 +++++++++++++
 tb/tb_tap_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_if.sv
// Serial scan pins and boundary-register control bundle for the IEEE 1149.1 TAP controller.
// master = board/tester side driving TMS/TDI/BSR_SO; slave = controller.
interface tap_controller_if;
    logic       TMS;
    logic       TDI;
    logic       BSR_SO;
    logic       TDO;
    logic       TDO_En;
    logic       ShiftBR;
    logic       ClockBR;
    logic       UpdateBR;
    logic       ModeControl;
    logic [3:0] State;

    modport master (
        output TMS, TDI, BSR_SO,
        input  TDO, TDO_En, ShiftBR, ClockBR, UpdateBR, ModeControl, State
    );

    modport slave (
        input  TMS, TDI, BSR_SO,
        output TDO, TDO_En, ShiftBR, ClockBR, UpdateBR, ModeControl, State
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with 2-bit IR, bypass register and boundary-register control decode.
// FSM/IR shift/bypass update on posedge TCLK; TDO, TDO_En and active IR on negedge; no backpressure.
module tap_controller (
    input  logic           TCLK,
    input  logic           RstBar,
    tap_controller_if.slave tap
);

    typedef enum logic [3:0] {
        TLR   = 4'd0,
        RTI   = 4'd1,
        SELDR = 4'd2,
        CAPDR = 4'd3,
        SHDR  = 4'd4,
        EX1DR = 4'd5,
        PAUDR = 4'd6,
        EX2DR = 4'd7,
        UPDDR = 4'd8,
        SELIR = 4'd9,
        CAPIR = 4'd10,
        SHIR  = 4'd11,
        EX1IR = 4'd12,
        PAUIR = 4'd13,
        EX2IR = 4'd14,
        UPDIR = 4'd15
    } tap_state_e;

    tap_state_e state_q, state_d;
    logic [1:0] ir_sh_q, ir_sh_d;
    logic [1:0] ir_q, ir_d;
    logic       byp_q, byp_d;
    logic       tdo_q, tdo_d;
    logic       tdo_en_q, tdo_en_d;
    logic       bsr_sel;

    // Instructions 00/01 select the boundary register; 1x select bypass.
    assign bsr_sel = ~ir_q[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tap.TMS ? TLR   : RTI;
            RTI:     state_d = tap.TMS ? SELDR : RTI;
            SELDR:   state_d = tap.TMS ? SELIR : CAPDR;
            CAPDR:   state_d = tap.TMS ? EX1DR : SHDR;
            SHDR:    state_d = tap.TMS ? EX1DR : SHDR;
            EX1DR:   state_d = tap.TMS ? UPDDR : PAUDR;
            PAUDR:   state_d = tap.TMS ? EX2DR : PAUDR;
            EX2DR:   state_d = tap.TMS ? UPDDR : SHDR;
            UPDDR:   state_d = tap.TMS ? SELDR : RTI;
            SELIR:   state_d = tap.TMS ? TLR   : CAPIR;
            CAPIR:   state_d = tap.TMS ? EX1IR : SHIR;
            SHIR:    state_d = tap.TMS ? EX1IR : SHIR;
            EX1IR:   state_d = tap.TMS ? UPDIR : PAUIR;
            PAUIR:   state_d = tap.TMS ? EX2IR : PAUIR;
            EX2IR:   state_d = tap.TMS ? UPDIR : SHIR;
            UPDIR:   state_d = tap.TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_sh_d = ir_sh_q;
        byp_d   = byp_q;
        if (state_q == CAPIR) begin
            ir_sh_d = 2'b01;
        end else if (state_q == SHIR) begin
            ir_sh_d = {tap.TDI, ir_sh_q[1]};
        end
        if (!bsr_sel) begin
            if (state_q == CAPDR) begin
                byp_d = 1'b0;
            end else if (state_q == SHDR) begin
                byp_d = tap.TDI;
            end
        end
    end

    // Negedge-side values: TDO launches half a cycle after the shift edge.
    always_comb begin
        ir_d     = ir_q;
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (state_q == TLR) begin
            ir_d = 2'b11;
        end else if (state_q == UPDIR) begin
            ir_d = ir_sh_q;
        end
        if (state_q == SHIR) begin
            tdo_d    = ir_sh_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == SHDR) begin
            tdo_d    = bsr_sel ? tap.BSR_SO : byp_q;
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            state_q <= TLR;
            ir_sh_q <= 2'b01;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_sh_q <= ir_sh_d;
            byp_q   <= byp_d;
        end
    end

    always_ff @(negedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            ir_q     <= 2'b11;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign tap.State       = state_q;
    assign tap.TDO         = tdo_q;
    assign tap.TDO_En      = tdo_en_q;
    assign tap.ShiftBR     = (state_q == SHDR);
    assign tap.ClockBR     = ~(((state_q == CAPDR) || (state_q == SHDR)) && bsr_sel);
    assign tap.UpdateBR    = (state_q == UPDDR) && bsr_sel;
    assign tap.ModeControl = (ir_q == 2'b00);

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: reset, IR scan, EXTEST and BYPASS DR scans, abort/TLR forcing, async reset.
module tb_tap_controller;

    logic TCLK;
    logic RstBar;
    int   checks;
    int   failures;

    tap_controller_if tap_if ();

    tap_controller dut (
        .TCLK   (TCLK),
        .RstBar (RstBar),
        .tap    (tap_if)
    );

    initial begin
        TCLK = 1'b0;
        forever #5 TCLK = ~TCLK;
    end

    task automatic tick(input logic tms, input logic tdi);
        tap_if.TMS = tms;
        tap_if.TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    task automatic half();
        @(negedge TCLK);
        #1;
    endtask

    task automatic test_reset();
        RstBar        = 1'b1;
        tap_if.TMS    = 1'b1;
        tap_if.TDI    = 1'b0;
        tap_if.BSR_SO = 1'b0;
        #2 RstBar = 1'b0;
        #1;
        checks++; if (tap_if.State !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", tap_if.State); end
        checks++; if (tap_if.TDO !== 1'b0 || tap_if.TDO_En !== 1'b0) begin failures++; $display("FAIL rst_tdo got=%b%b exp=00", tap_if.TDO, tap_if.TDO_En); end
        checks++; if ({tap_if.ShiftBR, tap_if.ClockBR, tap_if.UpdateBR, tap_if.ModeControl} !== 4'b0100) begin
            failures++; $display("FAIL rst_bsr_ctl got=%b%b%b%b exp=0100", tap_if.ShiftBR, tap_if.ClockBR, tap_if.UpdateBR, tap_if.ModeControl); end
        @(negedge TCLK);
        #1 RstBar = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        half();
        checks++; if (tap_if.State !== 4'd0 || tap_if.ModeControl !== 1'b0 || tap_if.ClockBR !== 1'b1 || tap_if.TDO_En !== 1'b0) begin
            failures++; $display("FAIL tlr_hold got state=%0d mc=%b cbr=%b en=%b exp 0/0/1/0", tap_if.State, tap_if.ModeControl, tap_if.ClockBR, tap_if.TDO_En); end
    endtask

    // Loads EXTEST: captured 01 shows on TDO as 1 then 0.
    task automatic test_ir_scan();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        checks++; if (tap_if.State !== 4'd11) begin failures++; $display("FAIL ir_shir_state got=%0d exp=11", tap_if.State); end
        half();
        checks++; if (tap_if.TDO !== 1'b1 || tap_if.TDO_En !== 1'b1) begin failures++; $display("FAIL ir_tdo0 got=%b en=%b exp=1 en=1", tap_if.TDO, tap_if.TDO_En); end
        tick(1'b0, 1'b0);
        half();
        checks++; if (tap_if.TDO !== 1'b0) begin failures++; $display("FAIL ir_tdo1 got=%b exp=0", tap_if.TDO); end
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        half();
        checks++; if (tap_if.TDO_En !== 1'b0) begin failures++; $display("FAIL ir_en_ex1 got=%b exp=0", tap_if.TDO_En); end
        tick(1'b1, 1'b0);
        checks++; if (tap_if.State !== 4'd15 || tap_if.ModeControl !== 1'b0) begin
            failures++; $display("FAIL ir_upd_pre got state=%0d mc=%b exp 15/0", tap_if.State, tap_if.ModeControl); end
        half();
        checks++; if (tap_if.ModeControl !== 1'b1) begin failures++; $display("FAIL ir_upd_mc got=%b exp=1", tap_if.ModeControl); end
        tick(1'b0, 1'b0);
        checks++; if (tap_if.State !== 4'd1) begin failures++; $display("FAIL ir_end_state got=%0d exp=1", tap_if.State); end
    endtask

    task automatic test_extest_dr();
        logic [7:0] pat;
        int         shift_cnt;
        int         clk_lo_cnt;
        pat        = 8'b1011_0010;
        shift_cnt  = 0;
        clk_lo_cnt = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (tap_if.State !== 4'd3 || tap_if.ClockBR !== 1'b0 || tap_if.ShiftBR !== 1'b0) begin
            failures++; $display("FAIL ext_capdr got state=%0d cbr=%b sbr=%b exp 3/0/0", tap_if.State, tap_if.ClockBR, tap_if.ShiftBR); end
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (tap_if.ShiftBR === 1'b1) shift_cnt++;
            if (tap_if.ClockBR === 1'b0) clk_lo_cnt++;
            tap_if.BSR_SO = pat[i];
            half();
            checks++; if (tap_if.TDO !== pat[i] || tap_if.TDO_En !== 1'b1) begin
                failures++; $display("FAIL ext_tdo[%0d] got=%b en=%b exp=%b en=1", i, tap_if.TDO, tap_if.TDO_En, pat[i]); end
            tick(i == 7, 1'b0);
        end
        checks++; if (shift_cnt != 8 || clk_lo_cnt != 8) begin failures++; $display("FAIL ext_shdr_cnt got sbr=%0d cbr_lo=%0d exp 8/8", shift_cnt, clk_lo_cnt); end
        checks++; if (tap_if.State !== 4'd5 || tap_if.ClockBR !== 1'b1 || tap_if.ShiftBR !== 1'b0) begin
            failures++; $display("FAIL ext_ex1 got state=%0d cbr=%b sbr=%b exp 5/1/0", tap_if.State, tap_if.ClockBR, tap_if.ShiftBR); end
        tick(1'b1, 1'b0);
        checks++; if (tap_if.UpdateBR !== 1'b1) begin failures++; $display("FAIL ext_upd got=%b exp=1", tap_if.UpdateBR); end
        tick(1'b0, 1'b0);
        checks++; if (tap_if.UpdateBR !== 1'b0 || tap_if.State !== 4'd1) begin
            failures++; $display("FAIL ext_rti got upd=%b state=%0d exp 0/1", tap_if.UpdateBR, tap_if.State); end
    endtask

    task automatic test_bypass();
        logic [2:0] tdi_v;
        logic [2:0] tdo_e;
        tdi_v = 3'b101;
        tdo_e = 3'b010;
        tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        half();
        tick(1'b0, 1'b0);
        checks++; if (tap_if.ModeControl !== 1'b0) begin failures++; $display("FAIL byp_load_mc got=%b exp=0", tap_if.ModeControl); end
        tap_if.BSR_SO = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (tap_if.ClockBR !== 1'b1) begin failures++; $display("FAIL byp_capdr_cbr got=%b exp=1", tap_if.ClockBR); end
        tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            half();
            checks++; if (tap_if.TDO !== tdo_e[i] || tap_if.ClockBR !== 1'b1 || tap_if.ShiftBR !== 1'b1 || tap_if.UpdateBR !== 1'b0) begin
                failures++; $display("FAIL byp_shdr[%0d] got tdo=%b cbr=%b sbr=%b upd=%b exp %b/1/1/0", i, tap_if.TDO, tap_if.ClockBR, tap_if.ShiftBR, tap_if.UpdateBR, tdo_e[i]); end
            tick(i == 2, tdi_v[i]);
        end
        tick(1'b1, 1'b0);
        checks++; if (tap_if.State !== 4'd8 || tap_if.UpdateBR !== 1'b0) begin
            failures++; $display("FAIL byp_upd got state=%0d upd=%b exp 8/0", tap_if.State, tap_if.UpdateBR); end
        tick(1'b0, 1'b0);
    endtask

    // Pause mid IR scan, then five TMS=1 (passing UpdIR) must land in TLR with IR forced to BYPASS.
    task automatic test_pause_and_five_ones();
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        half();
        checks++; if (tap_if.State !== 4'd13 || tap_if.ModeControl !== 1'b0) begin
            failures++; $display("FAIL pause_no_update got state=%0d mc=%b exp 13/0", tap_if.State, tap_if.ModeControl); end
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        half();
        checks++; if (tap_if.ModeControl !== 1'b1) begin failures++; $display("FAIL pause_upd_mc got=%b exp=1", tap_if.ModeControl); end
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        checks++; if (tap_if.State !== 4'd0) begin failures++; $display("FAIL five_ones_state got=%0d exp=0", tap_if.State); end
        half();
        checks++; if (tap_if.ModeControl !== 1'b0) begin failures++; $display("FAIL five_ones_ir got mc=%b exp=0", tap_if.ModeControl); end
    endtask

    task automatic test_reset_mid_scan();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tap_if.BSR_SO = 1'b1;
        half();
        checks++; if (tap_if.State !== 4'd4 || tap_if.TDO !== 1'b1 || tap_if.TDO_En !== 1'b1 || tap_if.ModeControl !== 1'b1) begin
            failures++; $display("FAIL mid_pre got state=%0d tdo=%b en=%b mc=%b exp 4/1/1/1", tap_if.State, tap_if.TDO, tap_if.TDO_En, tap_if.ModeControl); end
        #1 RstBar = 1'b0;
        #1;
        checks++; if (tap_if.State !== 4'd0 || tap_if.TDO !== 1'b0 || tap_if.TDO_En !== 1'b0) begin
            failures++; $display("FAIL mid_rst_core got state=%0d tdo=%b en=%b exp 0/0/0", tap_if.State, tap_if.TDO, tap_if.TDO_En); end
        checks++; if ({tap_if.ShiftBR, tap_if.ClockBR, tap_if.UpdateBR, tap_if.ModeControl} !== 4'b0100) begin
            failures++; $display("FAIL mid_rst_ctl got=%b%b%b%b exp=0100", tap_if.ShiftBR, tap_if.ClockBR, tap_if.UpdateBR, tap_if.ModeControl); end
        #1 RstBar = 1'b1;
        tick(1'b0, 1'b0);
        checks++; if (tap_if.State !== 4'd1) begin failures++; $display("FAIL mid_resume got=%0d exp=1", tap_if.State); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ir_scan();
        test_extest_dr();
        test_bypass();
        test_pause_and_five_ones();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
